// File: rtl/sprite_pixel_fetch.sv
// rtl/sprite_pixel_fetch.sv - playfield pixel fetch: board-cell lookup, sprite texel fetch, RGB332 out
//
// Purpose
//   For each pixel from the VGA timing generator this block finds the board
//   cell under the pixel and the texel offset inside that cell. It reads the
//   tile index from board RAM and then the texel from sprite RAM. It emits the
//   colour with the syncs delayed to match. The fixed latency is 3 clk from
//   px_* to rgb, with no stall.
//
//   Register stages
//     R1 (edge after input) : board_addr, in_field/active/tx/ty carried along
//     R2                    : spr_addr/spr_re from board_data; dis sampled here
//     R3                    : rgb from spr_data and the carried flags
//   Both RAMs return data in the cycle after their address register updates,
//   so board_data is consumed by R2 and spr_data by R3.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   dis               sprite RAM still being initialised; forces black and no reads
//   px_x, px_y        current pixel column / row
//   px_active         pixel is in the visible area
//   hsync_in/vsync_in syncs from the timing generator
//   board_addr        board RAM address, row*COLS+col (holds outside the field)
//   board_data        tile index from board RAM (values above 8 clamp to 8)
//   spr_addr, spr_re  sprite RAM address / read enable
//   spr_data          texel from sprite RAM
//   rgb               RGB332 output colour
//   hsync_out/vsync_out syncs delayed by 3 clk, idle high in reset

module sprite_pixel_fetch #(
  parameter int          X_OFF  = 200,
  parameter int          Y_OFF  = 0,
  parameter int          COLS   = 10,
  parameter int          ROWS   = 20,
  parameter int          TILE   = 24,
  parameter logic [7:0]  BORDER = 8'b01001001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dis,
  input  logic [9:0]  px_x,
  input  logic [9:0]  px_y,
  input  logic        px_active,
  input  logic        hsync_in,
  input  logic        vsync_in,
  output logic [7:0]  board_addr,
  input  logic [3:0]  board_data,
  output logic [12:0] spr_addr,
  output logic        spr_re,
  input  logic [7:0]  spr_data,
  output logic [7:0]  rgb,
  output logic        hsync_out,
  output logic        vsync_out
);

  localparam int FIELD_W   = COLS * TILE;
  localparam int FIELD_H   = ROWS * TILE;
  localparam int SPR_WORDS = TILE * TILE;
  localparam int CW        = $clog2(COLS);
  localparam int RW        = $clog2(ROWS);
  localparam int TW        = $clog2(TILE);

  localparam logic [9:0]    X_START = 10'(X_OFF);
  localparam logic [9:0]    Y_START = 10'(Y_OFF);
  localparam logic [TW-1:0] T_LAST  = TW'(TILE - 1);
  localparam logic [3:0]    MAX_IDX = 4'd8;

  // ---------------------------------------------------------------------------
  // S0: field test and tile/texel counters
  // ---------------------------------------------------------------------------

  // The offset is taken as an unsigned difference. Pixels left of or above
  // the field wrap to a large value, so a single upper-bound compare covers
  // both edges.
  logic [10:0] dx;
  logic [10:0] dy;
  logic        in_field;

  assign dx       = {1'b0, px_x} - 11'(X_OFF);
  assign dy       = {1'b0, px_y} - 11'(Y_OFF);
  assign in_field = px_active && (dx < 11'(FIELD_W)) && (dy < 11'(FIELD_H));

  // The counters replace the divide and modulo by TILE. tx/col step once per
  // clock and re-zero when px_x reaches the field's left column. ty/row step
  // once per new line (px_y changed) and re-zero at the field's top row. The
  // _d values are the coordinates of the current pixel, and they are also the
  // next register state.
  logic [TW-1:0] tx_q,  tx_d;
  logic [CW-1:0] col_q, col_d;
  logic [TW-1:0] ty_q,  ty_d;
  logic [RW-1:0] row_q, row_d;
  logic [9:0]    py_q;

  always_comb begin
    tx_d  = tx_q;
    col_d = col_q;
    if (px_x == X_START) begin
      tx_d  = '0;
      col_d = '0;
    end else if (tx_q == T_LAST) begin
      tx_d  = '0;
      col_d = col_q + CW'(1);
    end else begin
      tx_d  = tx_q + TW'(1);
    end
  end

  always_comb begin
    ty_d  = ty_q;
    row_d = row_q;
    if (px_y == Y_START) begin
      ty_d  = '0;
      row_d = '0;
    end else if (px_y != py_q) begin
      if (ty_q == T_LAST) begin
        ty_d  = '0;
        row_d = row_q + RW'(1);
      end else begin
        ty_d  = ty_q + TW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_q  <= '0;
      col_q <= '0;
      ty_q  <= '0;
      row_q <= '0;
      py_q  <= '0;
    end else begin
      tx_q  <= tx_d;
      col_q <= col_d;
      ty_q  <= ty_d;
      row_q <= row_d;
      py_q  <= px_y;
    end
  end

  // ---------------------------------------------------------------------------
  // R1: board address and carried pixel attributes
  // ---------------------------------------------------------------------------
  logic [7:0]    board_addr_q, board_addr_d;
  logic          s1_act_q, s1_in_q;
  logic [TW-1:0] s1_tx_q, s1_ty_q;

  // Outside the field the address holds, so the board RAM input stays quiet.
  assign board_addr_d = in_field ? (8'(row_d) * 8'(COLS) + 8'(col_d)) : board_addr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      board_addr_q <= '0;
      s1_act_q     <= 1'b0;
      s1_in_q      <= 1'b0;
      s1_tx_q      <= '0;
      s1_ty_q      <= '0;
    end else begin
      board_addr_q <= board_addr_d;
      s1_act_q     <= px_active;
      s1_in_q      <= in_field;
      s1_tx_q      <= tx_d;
      s1_ty_q      <= ty_d;
    end
  end

  // ---------------------------------------------------------------------------
  // R2: sprite address from the tile index; dis is sampled here
  // ---------------------------------------------------------------------------
  logic [3:0]  idx;
  logic [12:0] spr_addr_q, spr_addr_d;
  logic        spr_re_q, spr_re_d;
  logic        s2_act_q, s2_in_q, s2_dis_q;

  // Only sprites 0..8 exist. A corrupt board entry clamps to the last sprite
  // so the read never leaves the sprite image.
  assign idx = (board_data > MAX_IDX) ? MAX_IDX : board_data;

  assign spr_addr_d = s1_in_q
                    ? (13'(idx) * 13'(SPR_WORDS) + 13'(s1_ty_q) * 13'(TILE) + 13'(s1_tx_q))
                    : spr_addr_q;
  assign spr_re_d   = s1_in_q & ~dis;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spr_addr_q <= '0;
      spr_re_q   <= 1'b0;
      s2_act_q   <= 1'b0;
      s2_in_q    <= 1'b0;
      s2_dis_q   <= 1'b0;
    end else begin
      spr_addr_q <= spr_addr_d;
      spr_re_q   <= spr_re_d;
      s2_act_q   <= s1_act_q;
      s2_in_q    <= s1_in_q;
      s2_dis_q   <= dis;
    end
  end

  // ---------------------------------------------------------------------------
  // R3: colour select
  // ---------------------------------------------------------------------------
  logic [7:0] rgb_q, rgb_d;

  // dis blanks the whole visible area, including the border, because the
  // display is not meaningful until the sprites are loaded.
  always_comb begin
    rgb_d = spr_data;
    if (!s2_act_q) begin
      rgb_d = 8'h00;
    end else if (s2_dis_q) begin
      rgb_d = 8'h00;
    end else if (!s2_in_q) begin
      rgb_d = BORDER;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb_q <= 8'h00;
    end else begin
      rgb_q <= rgb_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Sync delay: three registers to match R1..R3
  // ---------------------------------------------------------------------------
  logic [2:0] hs_q, vs_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs_q <= 3'b111;
      vs_q <= 3'b111;
    end else begin
      hs_q <= {hs_q[1:0], hsync_in};
      vs_q <= {vs_q[1:0], vsync_in};
    end
  end

  assign board_addr = board_addr_q;
  assign spr_addr   = spr_addr_q;
  assign spr_re     = spr_re_q;
  assign rgb        = rgb_q;
  assign hsync_out  = hs_q[2];
  assign vsync_out  = vs_q[2];

endmodule

// File: tb/tb_sprite_pixel_fetch.sv
// tb/tb_sprite_pixel_fetch.sv - self-checking bench for sprite_pixel_fetch against a division-based pixel model
module tb_sprite_pixel_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dis = 1'b0;
  logic [9:0]  px_x = '0;
  logic [9:0]  px_y = '0;
  logic        px_active = 1'b0;
  logic        hsync_in = 1'b1;
  logic        vsync_in = 1'b1;
  logic [7:0]  board_addr;
  logic [3:0]  board_data;
  logic [12:0] spr_addr;
  logic        spr_re;
  logic [7:0]  spr_data;
  logic [7:0]  rgb;
  logic        hsync_out;
  logic        vsync_out;

  sprite_pixel_fetch dut (
    .clk       (clk),
    .rst       (rst),
    .dis       (dis),
    .px_x      (px_x),
    .px_y      (px_y),
    .px_active (px_active),
    .hsync_in  (hsync_in),
    .vsync_in  (vsync_in),
    .board_addr(board_addr),
    .board_data(board_data),
    .spr_addr  (spr_addr),
    .spr_re    (spr_re),
    .spr_data  (spr_data),
    .rgb       (rgb),
    .hsync_out (hsync_out),
    .vsync_out (vsync_out)
  );

  always #5 clk = ~clk;

  // Memories: the read data follows the registered address combinationally.
  logic [3:0] board_mem [0:255];
  logic [7:0] spr_mem   [0:8191];
  assign board_data = board_mem[board_addr];
  assign spr_data   = spr_mem[spr_addr];

  int compared   = 0;
  int mismatched = 0;

  // History of every driven input cycle. base is the first index after the
  // most recent reset release.
  logic [9:0] h_x   [0:65535];
  logic [9:0] h_y   [0:65535];
  logic       h_act [0:65535];
  logic       h_dis [0:65535];
  logic       h_hs  [0:65535];
  logic       h_vs  [0:65535];
  int         n    = 0;
  int         base = 0;
  logic [7:0] exp_ba = 8'h00;

  function automatic bit in_fld(int k);
    return h_act[k] && (h_x[k] >= 10'd200) && (h_x[k] < 10'd440) && (h_y[k] < 10'd480);
  endfunction

  function automatic int ref_baddr(int k);
    return (int'(h_y[k]) / 24) * 10 + (int'(h_x[k]) - 200) / 24;
  endfunction

  function automatic int ref_saddr(int k);
    int idx;
    idx = int'(board_mem[ref_baddr(k)]);
    if (idx > 8) idx = 8;
    return idx * 576 + (int'(h_y[k]) % 24) * 24 + (int'(h_x[k]) - 200) % 24;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, n);
    end
  endtask

  // Runs at a negedge. Outputs now reflect inputs up to index n-1: board_addr
  // for n-1, spr_* for n-2, rgb and syncs for n-3.
  task automatic check_outputs();
    int  k;
    bit  re;
    logic [7:0] e_rgb;

    k = n - 1;
    if (k >= base && in_fld(k)) exp_ba = 8'(ref_baddr(k));
    chk("board_addr", 32'(board_addr), 32'(exp_ba));
    if (k >= base && in_fld(k) && h_x[k] == 10'd247 && h_y[k] == 10'd23)
      chk("board_addr_247_23", 32'(board_addr), 32'd1);
    if (k >= base && in_fld(k) && h_x[k] == 10'd200 && h_y[k] == 10'd24)
      chk("board_addr_200_24", 32'(board_addr), 32'd10);

    k = n - 2;
    if (k >= base) begin
      re = in_fld(k) && !h_dis[k+1];
      chk("spr_re", 32'(spr_re), 32'(re));
      if (re) begin
        chk("spr_addr", 32'(spr_addr), 32'(ref_saddr(k)));
        if (h_x[k] == 10'd200 && h_y[k] == 10'd0)  chk("spr_addr_200_0", 32'(spr_addr), 32'd576);
        if (h_x[k] == 10'd247 && h_y[k] == 10'd23) chk("spr_addr_247_23", 32'(spr_addr), 32'd2303);
        if (h_x[k] == 10'd200 && h_y[k] == 10'd24) chk("spr_addr_clamp", 32'(spr_addr), 32'd4608);
      end
    end else begin
      chk("spr_re_flushed", 32'(spr_re), 32'd0);
    end

    k = n - 3;
    if (k >= base) begin
      if (!h_act[k] || h_dis[k+1]) e_rgb = 8'h00;
      else if (!in_fld(k))        e_rgb = 8'h49;
      else                        e_rgb = spr_mem[ref_saddr(k)];
      chk("rgb", 32'(rgb), 32'(e_rgb));
      if (h_act[k] && !h_dis[k+1] && h_x[k] == 10'd200 && h_y[k] == 10'd0)
        chk("rgb_200_0", 32'(rgb), 32'h1C);
      if (h_act[k] && !h_dis[k+1] && h_x[k] == 10'd100)
        chk("rgb_border", 32'(rgb), 32'h49);
      chk("hsync_out", 32'(hsync_out), 32'(h_hs[k]));
      chk("vsync_out", 32'(vsync_out), 32'(h_vs[k]));
    end else begin
      chk("rgb_flushed", 32'(rgb), 32'd0);
      chk("hsync_flushed", 32'(hsync_out), 32'd1);
      chk("vsync_flushed", 32'(vsync_out), 32'd1);
    end
  endtask

  task automatic record();
    h_x[n] = px_x; h_y[n] = px_y; h_act[n] = px_active;
    h_dis[n] = dis; h_hs[n] = hsync_in; h_vs[n] = vsync_in;
    n++;
  endtask

  task automatic step(input logic [9:0] x, input logic [9:0] y, input logic act, input logic d);
    @(negedge clk);
    check_outputs();
    px_x = x; px_y = y; px_active = act; dis = d;
    hsync_in = 1'($urandom); vsync_in = 1'($urandom);
    record();
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_rgb"},        32'(rgb),        32'd0);
    chk({tag, "_spr_re"},     32'(spr_re),     32'd0);
    chk({tag, "_hsync"},      32'(hsync_out),  32'd1);
    chk({tag, "_vsync"},      32'(vsync_out),  32'd1);
    chk({tag, "_board_addr"}, 32'(board_addr), 32'd0);
    chk({tag, "_spr_addr"},   32'(spr_addr),   32'd0);
  endtask

  // Called at a negedge while rst is high: drives an idle pixel, then releases.
  task automatic release_reset();
    px_x = '0; px_y = '0; px_active = 1'b0; dis = 1'b0;
    hsync_in = 1'b1; vsync_in = 1'b1;
    rst = 1'b0;
    exp_ba = 8'h00;
    base = n;
    record();
  endtask

  // mode 0: clean, mode 1: random dis / active drops, mode 2: dis held high.
  task automatic sweep(input int y0, input int y1, input int xa, input int xb, input int mode);
    logic d, a;
    for (int y = y0; y <= y1; y++) begin
      d = (mode == 2);
      step(10'd0, 10'(y), 1'b0, d);
      step(10'd1, 10'(y), 1'b0, d);
      for (int x = xa; x <= xb; x++) begin
        a = 1'b1;
        if (mode == 1) begin
          d = (($urandom % 8) == 0);
          a = (($urandom % 32) != 0);
        end
        step(10'(x), 10'(y), a, d);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++)  board_mem[i] = 4'($urandom);
    for (int i = 0; i < 8192; i++) spr_mem[i]   = 8'($urandom);
    board_mem[0]  = 4'd1;
    board_mem[1]  = 4'd3;
    board_mem[10] = 4'd12;
    spr_mem[576]  = 8'h1C;

    @(negedge clk);
    check_reset_values("reset");
    @(negedge clk);
    release_reset();

    sweep(0, 29, 95, 445, 0);
    sweep(30, 55, 95, 445, 1);

    sweep(0, 99, 195, 232, 0);
    sweep(100, 140, 195, 232, 1);
    sweep(141, 485, 195, 232, 0);

    sweep(0, 30, 195, 445, 2);

    sweep(0, 3, 195, 445, 0);
    for (int x = 195; x < 230; x++) step(10'(x), 10'd4, 1'b1, 1'b0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_reset_values("midreset");
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    release_reset();

    sweep(0, 10, 195, 445, 1);
    for (int i = 0; i < 4; i++) step(10'd0, 10'd11, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
